// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-requester round-robin arbiter that drives the select line of a
// downstream 2:1 data mux. One source owns the mux at a time for a burst of at
// most BURST_LEN accepted beats. When a grant is released, the other source is
// preferred, so two busy sources alternate without an idle gap.
//
// Optional build feature:
//   MUX_ARB_SWITCH_CNT_EN - adds an 8-bit saturating 'switch_cnt' output that
//                           counts owner changes (A->B or B->A).

module mux_sel_arbiter #(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic             beat,
   output logic             sel,
   output logic             grant_a,
   output logic             grant_b,
   output logic             busy,
`ifdef MUX_ARB_SWITCH_CNT_EN
   output logic [7:0]       switch_cnt,
`endif
   output logic [CNT_W-1:0] beat_cnt
);

   // The beat_cnt value at which one more beat ends the burst.
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;

   // lastOwner: 0 = A released most recently, 1 = B released most recently.
   // The tie-break in IDLE favours the source that is not lastOwner.
   logic             lastOwner;
   logic             lastOwnerNext;
   logic [CNT_W-1:0] cntNext;
   logic             selNext;
   logic             releaseA;
   logic             releaseB;

   // A grant is released when its requester drops, or when a beat arrives on
   // the final beat slot of the burst.
   always_comb begin
      releaseA = !req_a || (beat && (beat_cnt == LAST_BEAT));
      releaseB = !req_b || (beat && (beat_cnt == LAST_BEAT));
   end

   // Next-state, burst counter and ownership bookkeeping. On release the other
   // source wins if it is requesting; otherwise the same source is re-granted
   // a fresh burst if it still requests; otherwise the arbiter goes idle.
   always_comb begin
      stateNext     = state;
      lastOwnerNext = lastOwner;
      cntNext       = beat_cnt;
      case (state)
         IDLE: begin
            if (req_a && req_b) begin
               stateNext = lastOwner ? GNT_A : GNT_B;
            end else if (req_a) begin
               stateNext = GNT_A;
            end else if (req_b) begin
               stateNext = GNT_B;
            end
         end
         GNT_A: begin
            if (releaseA) begin
               lastOwnerNext = 1'b0;
               cntNext       = '0;
               if (req_b) begin
                  stateNext = GNT_B;
               end else if (req_a) begin
                  stateNext = GNT_A;
               end else begin
                  stateNext = IDLE;
               end
            end else if (beat && (beat_cnt < LAST_BEAT)) begin
               cntNext = beat_cnt + CNT_W'(1);
            end
         end
         GNT_B: begin
            if (releaseB) begin
               lastOwnerNext = 1'b1;
               cntNext       = '0;
               if (req_a) begin
                  stateNext = GNT_A;
               end else if (req_b) begin
                  stateNext = GNT_B;
               end else begin
                  stateNext = IDLE;
               end
            end else if (beat && (beat_cnt < LAST_BEAT)) begin
               cntNext = beat_cnt + CNT_W'(1);
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // The mux select follows the owner and holds its last value while idle so
   // the mux output does not glitch between bursts.
   always_comb begin
      selNext = sel;
      case (stateNext)
         GNT_A:   selNext = 1'b0;
         GNT_B:   selNext = 1'b1;
         default: selNext = sel;
      endcase
   end

   // State and registered outputs; reset makes A win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lastOwner <= 1'b1;
         beat_cnt  <= '0;
         sel       <= 1'b0;
         grant_a   <= 1'b0;
         grant_b   <= 1'b0;
      end else begin
         state     <= stateNext;
         lastOwner <= lastOwnerNext;
         beat_cnt  <= cntNext;
         sel       <= selNext;
         grant_a   <= (stateNext == GNT_A);
         grant_b   <= (stateNext == GNT_B);
      end
   end

   // Busy whenever either source owns the mux.
   always_comb begin
      busy = grant_a | grant_b;
   end

`ifdef MUX_ARB_SWITCH_CNT_EN
   // hasOwned marks that some source has held the mux since reset. Together
   // with sel (which holds the most recent owner through idle periods), it lets
   // an owner change be detected whether it happens directly or via IDLE.
   logic hasOwned;
   logic ownerChange;

   // An owner change is a grant to the source other than the previous owner.
   always_comb begin
      ownerChange = hasOwned &&
                    (((stateNext == GNT_A) && sel) ||
                     ((stateNext == GNT_B) && !sel));
   end

   // Saturating count of owner changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         hasOwned   <= 1'b0;
         switch_cnt <= 8'd0;
      end else begin
         if (stateNext != IDLE) begin
            hasOwned <= 1'b1;
         end
         if (ownerChange && (switch_cnt != 8'hFF)) begin
            switch_cnt <= switch_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
// Self-checking bench for mux_sel_arbiter with BURST_LEN = 4. A table of
// hand-derived vectors drives the arbiter; each vector's expected outputs are
// queued when it is driven and popped and compared one cycle later. A small
// downstream mux model checks that sel picks the granted source's data.

`timescale 1ns/1ps

module tb_mux_sel_arbiter;

   localparam int BURST_LEN = 4;
   localparam int CNT_W     = 8;

   logic             clk;
   logic             rst;
   logic             req_a;
   logic             req_b;
   logic             beat;
   logic             sel;
   logic             grant_a;
   logic             grant_b;
   logic             busy;
   logic [CNT_W-1:0] beat_cnt;
`ifdef MUX_ARB_SWITCH_CNT_EN
   logic [7:0]       switch_cnt;
`endif

   mux_sel_arbiter #(
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .req_b      (req_b),
      .beat       (beat),
      .sel        (sel),
      .grant_a    (grant_a),
      .grant_b    (grant_b),
      .busy       (busy),
`ifdef MUX_ARB_SWITCH_CNT_EN
      .switch_cnt (switch_cnt),
`endif
      .beat_cnt   (beat_cnt)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic             rst;
      logic             ra;
      logic             rb;
      logic             bt;
      logic             sel;
      logic             ga;
      logic             gb;
      logic [CNT_W-1:0] cnt;
   } vec_t;

   typedef struct {
      int               id;
      logic             sel;
      logic             ga;
      logic             gb;
      logic             busy;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;

   // Downstream mux model driven by the arbiter's sel.
   logic [7:0] dataA;
   logic [7:0] dataB;
   logic [7:0] muxOut;
   always_comb begin
      muxOut = sel ? dataB : dataA;
   end

   task automatic addVec(input logic r, input logic ra, input logic rb,
                         input logic bt, input logic s, input logic ga,
                         input logic gb, input int c);
      vec_t v;
      v.rst = r;  v.ra = ra; v.rb = rb; v.bt = bt;
      v.sel = s;  v.ga = ga; v.gb = gb; v.cnt = CNT_W'(c);
      vecs.push_back(v);
   endtask

   task automatic checkOutput();
      exp_t e;
      logic [7:0] wantData;
      testsRun++;
      if (expQ.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard: got empty queue, required a pending entry");
         return;
      end
      e = expQ.pop_front();
      if (sel !== e.sel || grant_a !== e.ga || grant_b !== e.gb ||
          busy !== e.busy || beat_cnt !== e.cnt) begin
         testsFailed++;
         $display("[TB] FAIL vec%0d: got sel=%b ga=%b gb=%b busy=%b cnt=%0d, required sel=%b ga=%b gb=%b busy=%b cnt=%0d",
                  e.id, sel, grant_a, grant_b, busy, beat_cnt,
                  e.sel, e.ga, e.gb, e.busy, e.cnt);
      end
      if (e.ga || e.gb) begin
         wantData = e.gb ? dataB : dataA;
         testsRun++;
         if (muxOut !== wantData) begin
            testsFailed++;
            $display("[TB] FAIL mux%0d: got data=%h, required %h", e.id, muxOut, wantData);
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      rst   = v.rst;
      req_a = v.ra;
      req_b = v.rb;
      beat  = v.bt;
      dataA = 8'($urandom_range(0, 127));
      dataB = 8'($urandom_range(128, 255));
      e.id   = id;
      e.sel  = v.sel;
      e.ga   = v.ga;
      e.gb   = v.gb;
      e.busy = v.ga | v.gb;
      e.cnt  = v.cnt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

`ifdef MUX_ARB_SWITCH_CNT_EN
   task automatic checkSwitch(input string name, input int want);
      testsRun++;
      if (switch_cnt !== 8'(want)) begin
         testsFailed++;
         $display("[TB] FAIL %s: got switch_cnt=%0d, required %0d", name, switch_cnt, want);
      end
   endtask
`endif

   initial begin
      rst   = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      beat  = 1'b0;
      dataA = 8'h00;
      dataB = 8'hFF;

      //      rst ra   rb   bt   sel  ga   gb   cnt
      // Reset held with both requesting, then A wins the first tie.
      addVec(1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 0);
      addVec(1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 0);
      addVec(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0, 0);
      // Contention: four beats on A, then switch straight to B, then back.
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0, 1);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0, 2);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0, 3);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 0);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 1);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 2);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 3);
      addVec(1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0, 0);
      // Single requester: burst expiry re-grants A with a fresh count.
      addVec(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 1);
      addVec(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 2);
      addVec(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 3);
      addVec(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 0);
      addVec(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 0);
      // A drops, B takes over; B drops at cnt=1 -> IDLE with sel held at 1.
      addVec(1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1, 0);
      addVec(1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1, 1);
      addVec(1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0);
      addVec(1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 0);
      addVec(1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 0);
      // Mid-burst reset at cnt=2.
      addVec(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 1);
      addVec(1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 2);
      addVec(1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 0);
      // After reset B alone is granted; a beat with req dropped still releases.
      addVec(1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1, 0);
      addVec(1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 0);
      // Tie after B released goes to A; tie after A released goes to B.
      addVec(1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0, 0);
      addVec(1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0);
      addVec(1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1, 0);
      addVec(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i], i);
      end

`ifdef MUX_ARB_SWITCH_CNT_EN
      // Contention from reset: grant A, 4 beats, B, 4 beats, A, 3 beats.
      @(negedge clk);
      rst = 1'b1; req_a = 1'b1; req_b = 1'b1; beat = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checkSwitch("switch_three_bursts", 2);
      // Keep contending long enough for well over 255 owner changes.
      repeat (1250) @(negedge clk);
      checkSwitch("switch_saturate", 255);
      req_a = 1'b0; req_b = 1'b0; beat = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
